alu_exec_unit: RTL

- Parametrised successor to the combinational ALU control decoder.
- Decodes the full RV32I ALU operation set from aluop/funct3/funct7/op5 and executes it on two operands with a registered result.
- Optionally adds RV32M multiply/divide as an iterative multi-cycle FSM with a valid/ready handshake.
- Sits in the EX stage; the hazard unit uses in_ready and busy to stall IF/ID/EX.

---
 rtl/alu_exec_unit.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: full RV32I operation decode with a registered result,
// plus an optional iterative RV32M multiply/divide unit.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid, in_ready  operation handshake (in_ready = unit idle)
//   flush               synchronous abort of accepted/in-flight work
//   aluop, funct3,      operation select (instruction fields)
//   funct7_5, funct7_0,
//   op5
//   src_a, src_b        operands
//   out_valid           one-cycle pulse, result valid
//   result, zero        registered result and (result == 0)
//   busy                multi-cycle operation in flight
module alu_exec_unit #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [1:0]      aluop,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic            op5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    logic [SHW-1:0]  shamt;
    logic            is_m;
    logic            accept;
    logic            idle;
    logic            m_done;
    logic [XLEN-1:0] m_res;
    logic [XLEN-1:0] base_res;
    logic [XLEN-1:0] sra_res;

    assign shamt    = src_b[SHW-1:0];
    assign is_m     = ENABLE_M && (aluop == 2'b10) && op5 && funct7_0;
    assign in_ready = idle;
    assign busy     = ~idle;
    assign accept   = in_valid & idle & ~flush;

    // Kept separate so the arithmetic shift is not turned logical by
    // mixing with unsigned operands in a conditional expression.
    assign sra_res = $signed(src_a) >>> shamt;

    always_comb begin
        base_res = '0;
        unique case (aluop)
            2'b00: base_res = src_a + src_b;
            2'b01: base_res = src_a - src_b;
            2'b11: base_res = src_b;
            default: begin
                unique case (funct3)
                    3'b000: base_res = (op5 && funct7_5) ? src_a - src_b
                                                         : src_a + src_b;
                    3'b001: base_res = src_a << shamt;
                    3'b010: base_res = {{(XLEN-1){1'b0}},
                                        $signed(src_a) < $signed(src_b)};
                    3'b011: base_res = {{(XLEN-1){1'b0}}, src_a < src_b};
                    3'b100: base_res = src_a ^ src_b;
                    3'b101: base_res = funct7_5 ? sra_res : src_a >> shamt;
                    3'b110: base_res = src_a | src_b;
                    default: base_res = src_a & src_b;
                endcase
            end
        endcase
    end

    generate
        if (ENABLE_M) begin : g_m
            state_t            state;
            state_t            state_nx;
            logic [SHW-1:0]    cnt;
            logic [2:0]        op;
            logic              neg_a;
            logic              neg_b;
            logic              b_zero;
            logic [XLEN-1:0]   mag_b;
            // acc: product high word / partial remainder
            // lo:  multiplier / dividend, shifted into product low / quotient
            logic [XLEN-1:0]   acc;
            logic [XLEN-1:0]   lo;
            logic              sign_a;
            logic              sign_b;
            logic              neg_a_in;
            logic              neg_b_in;
            logic [XLEN-1:0]   mag_a_in;
            logic [XLEN-1:0]   mag_b_in;
            logic [XLEN:0]     mul_sum;
            logic [XLEN:0]     div_sh;
            logic [XLEN:0]     div_diff;
            logic              div_ge;
            logic [2*XLEN-1:0] prod;
            logic [2*XLEN-1:0] prod_s;
            logic [XLEN-1:0]   quo_s;
            logic [XLEN-1:0]   rem_s;

            always_comb begin
                sign_a = 1'b0;
                sign_b = 1'b0;
                unique case (funct3)
                    3'b001, 3'b100, 3'b110: begin
                        sign_a = 1'b1;
                        sign_b = 1'b1;
                    end
                    3'b010: sign_a = 1'b1;
                    default: ;
                endcase
            end

            assign neg_a_in = sign_a & src_a[XLEN-1];
            assign neg_b_in = sign_b & src_b[XLEN-1];
            assign mag_a_in = neg_a_in ? -src_a : src_a;
            assign mag_b_in = neg_b_in ? -src_b : src_b;

            assign mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, mag_b} : '0);
            assign div_sh   = {acc, lo[XLEN-1]};
            assign div_ge   = div_sh >= {1'b0, mag_b};
            assign div_diff = div_sh - {1'b0, mag_b};

            always_ff @(posedge clk or posedge reset) begin
                if (reset) state <= IDLE;
                else       state <= state_nx;
            end

            always_comb begin
                state_nx = state;
                if (flush) begin
                    state_nx = IDLE;
                end else begin
                    unique case (state)
                        IDLE:    if (in_valid && is_m) state_nx = CALC;
                        CALC:    if (cnt == SHW'(XLEN-1)) state_nx = FINISH;
                        FINISH:  state_nx = IDLE;
                        default: state_nx = IDLE;
                    endcase
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt    <= '0;
                    op     <= '0;
                    neg_a  <= 1'b0;
                    neg_b  <= 1'b0;
                    b_zero <= 1'b0;
                    mag_b  <= '0;
                    acc    <= '0;
                    lo     <= '0;
                end else if (state == IDLE) begin
                    if (accept && is_m) begin
                        cnt    <= '0;
                        op     <= funct3;
                        neg_a  <= neg_a_in;
                        neg_b  <= neg_b_in;
                        b_zero <= (src_b == '0);
                        mag_b  <= mag_b_in;
                        acc    <= '0;
                        lo     <= mag_a_in;
                    end
                end else if (state == CALC) begin
                    cnt <= cnt + 1'b1;
                    if (op[2]) begin
                        acc <= div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
                        lo  <= {lo[XLEN-2:0], div_ge};
                    end else begin
                        acc <= mul_sum[XLEN:1];
                        lo  <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                end
            end

            // Divide by zero yields an all-ones quotient regardless of
            // sign; the remainder naturally ends up equal to the dividend.
            always_comb begin
                prod   = {acc, lo};
                prod_s = (neg_a ^ neg_b) ? -prod : prod;
                quo_s  = b_zero ? '1 : ((neg_a ^ neg_b) ? -lo : lo);
                rem_s  = neg_a ? -acc : acc;
                m_res  = '0;
                unique case (op)
                    3'b000:                 m_res = prod_s[XLEN-1:0];
                    3'b001, 3'b010, 3'b011: m_res = prod_s[2*XLEN-1:XLEN];
                    3'b100, 3'b101:         m_res = quo_s;
                    default:                m_res = rem_s;
                endcase
            end

            assign idle   = (state == IDLE);
            assign m_done = (state == FINISH) && !flush;
        end else begin : g_no_m
            assign idle   = 1'b1;
            assign m_done = 1'b0;
            assign m_res  = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            if (accept && !is_m) begin
                result    <= base_res;
                zero      <= (base_res == '0);
                out_valid <= 1'b1;
            end else if (m_done) begin
                result    <= m_res;
                zero      <= (m_res == '0);
                out_valid <= 1'b1;
            end
        end
    end

endmodule
